// File: rtl/ps2_scan_receiver.sv
// rtl/ps2_scan_receiver.sv - PS/2 keyboard frame receiver with scan-code FIFO
//
// Receives PS/2 keyboard frames using the system clock. Both PS/2 lines are
// synchronised, and ps2_clk is glitch-filtered. Each 1->0 transition of the
// filtered clock samples ps2_data. A frame is 11 bits: start, 8 data bits
// LSB first, odd parity, and stop. Scan codes from good frames are pushed
// into a first-word fall-through FIFO. Parity errors, stop-bit errors and
// timeout errors are reported as single-cycle pulses.
//
// Ports:
//   clk         system clock, all logic on posedge
//   reset       asynchronous, active-high
//   ps2_clk     raw PS/2 clock line (asynchronous)
//   ps2_data    raw PS/2 data line (asynchronous)
//   read        pop FIFO head; ignored when empty
//   scan_code   FIFO head, 8'h00 when empty
//   scan_ready  FIFO not empty
//   fifo_count  number of entries held
//   parity_err  1-cycle pulse, parity mismatch (CHECK_PARITY=1 only)
//   frame_err   1-cycle pulse, stop bit 0 or inter-edge timeout
//   overflow    1-cycle pulse, good frame dropped because FIFO full

module ps2_scan_receiver #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter bit CHECK_PARITY   = 1'b1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ps2_clk,
  input  logic                              ps2_data,
  input  logic                              read,
  output logic [7:0]                        scan_code,
  output logic                              scan_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              parity_err,
  output logic                              frame_err,
  output logic                              overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers. These reset to 1 because an idle PS/2 bus is high.
  // ---------------------------------------------------------------------------
  logic [1:0] clk_sync;
  logic [1:0] data_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // ---------------------------------------------------------------------------
  // Glitch filter on the clock line.
  // filter_cnt counts consecutive samples that disagree with the filtered value.
  // On the FILTER_LEN-th disagreeing sample, the filtered value follows the
  // line. sample_event goes high in the same cycle that the filtered clock
  // first reads 0, so it marks the falling edge.
  // ---------------------------------------------------------------------------
  logic             ps2_clk_filtered;
  logic [FLT_W-1:0] filter_cnt;
  logic             sample_event;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps2_clk_filtered <= 1'b1;
      filter_cnt       <= '0;
      sample_event     <= 1'b0;
    end else begin
      sample_event <= 1'b0;
      if (clk_sync[1] == ps2_clk_filtered) begin
        filter_cnt <= '0;
      end else if (filter_cnt == FLT_W'(FILTER_LEN - 1)) begin
        ps2_clk_filtered <= clk_sync[1];
        filter_cnt       <= '0;
        sample_event     <= ~clk_sync[1];
      end else begin
        filter_cnt <= filter_cnt + FLT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t          state, state_next;
  logic [2:0]      bit_cnt, bit_cnt_next;
  logic [7:0]      shift_reg, shift_next;
  logic            parity_bit, parity_next;
  logic [TO_W-1:0] timeout_cnt;
  logic            timeout_hit;
  logic            push;
  logic            set_parity_err;
  logic            set_frame_err;
  logic            data_bit;

  assign data_bit    = data_sync[1];
  assign timeout_hit = (state != ST_IDLE) && (timeout_cnt == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_next;
      bit_cnt    <= bit_cnt_next;
      shift_reg  <= shift_next;
      parity_bit <= parity_next;
      parity_err <= set_parity_err;
      frame_err  <= set_frame_err;
    end
  end

  // The timeout counter measures the gap since the last falling edge while a
  // frame is in flight. It saturates at TIMEOUT_CYCLES until the FSM leaves
  // the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_cnt <= '0;
    end else if (state == ST_IDLE || sample_event) begin
      timeout_cnt <= '0;
    end else if (timeout_cnt != TO_W'(TIMEOUT_CYCLES)) begin
      timeout_cnt <= timeout_cnt + TO_W'(1);
    end
  end

  always_comb begin
    state_next     = state;
    bit_cnt_next   = bit_cnt;
    shift_next     = shift_reg;
    parity_next    = parity_bit;
    push           = 1'b0;
    set_parity_err = 1'b0;
    set_frame_err  = 1'b0;

    if (sample_event) begin
      case (state)
        ST_IDLE: begin
          // A high data line on a falling edge is not a start bit, so it is ignored.
          if (!data_bit) begin
            state_next   = ST_DATA;
            bit_cnt_next = '0;
          end
        end
        ST_DATA: begin
          shift_next   = {data_bit, shift_reg[7:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_next = ST_PARITY;
          end
        end
        ST_PARITY: begin
          parity_next = data_bit;
          state_next  = ST_STOP;
        end
        ST_STOP: begin
          state_next = ST_IDLE;
          if (!data_bit) begin
            set_frame_err = 1'b1;
          end else if (CHECK_PARITY && ((^shift_reg ^ parity_bit) == 1'b0)) begin
            // Odd parity: data plus parity must have an odd number of ones.
            set_parity_err = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_next    = ST_IDLE;
      set_frame_err = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan-code FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             do_pop;
  logic             do_push;

  assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
  assign do_pop    = read && (count != '0);
  // When the FIFO is full, a pop in the same cycle frees the slot for the push.
  assign do_push   = push && (!fifo_full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_mem[wr_ptr] <= shift_reg;
    end
  end

  // The pointers are PTR_W bits wide, so they wrap modulo the power-of-two depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && fifo_full && !do_pop;
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign scan_ready = (count != '0);
  assign scan_code  = scan_ready ? fifo_mem[rd_ptr] : 8'h00;
  assign fifo_count = count;

endmodule
